// File: rtl/pipe_drain_buffer_pkg.sv
// Shared constants and helpers for the pipeline drain buffer.
// Holds the default geometry and the constant clog2 used to size counters and pointers.
package pipe_drain_buffer_pkg;

   localparam int DEF_DATA_WIDTH   = 16;
   localparam int DEF_PIPE_LATENCY = 4;
   localparam int DEF_DEPTH        = 8;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/drain_buf_ram.sv
// Simple dual-port word store: synchronous write, asynchronous read.
// Zero read latency; no flow control, the caller owns occupancy and pointers.
module drain_buf_ram #(
   parameter int DW    = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [DW-1:0] rd_data_o
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/pipe_drain_buffer.sv
// Credit-guarded FWFT skid buffer that absorbs every result of a fixed-latency pipeline.
// Push to m_valid in one edge; issue_ok withdraws credits so in-flight results always fit.
module pipe_drain_buffer
   import pipe_drain_buffer_pkg::*;
#(
   parameter int C_DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int C_PIPE_LATENCY = DEF_PIPE_LATENCY,
   parameter int C_DEPTH        = DEF_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue,
   output logic                    issue_ok,
   input  logic                    pipe_valid,
   input  logic [C_DATA_WIDTH-1:0] pipe_data,
   output logic                    m_valid,
   output logic [C_DATA_WIDTH-1:0] m_data,
   input  logic                    m_ready,
   output logic [clog2(C_DEPTH):0] count,
   output logic                    err
);

   localparam int AW = clog2(C_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(C_DEPTH);
   localparam bit CFG_OK = (C_PIPE_LATENCY >= 1) && (C_PIPE_LATENCY <= 64) &&
                           (C_DEPTH >= C_PIPE_LATENCY) && (C_DEPTH >= 2) &&
                           ((1 << AW) == C_DEPTH);

   if (!CFG_OK) begin : g_cfg_err
      $error("pipe_drain_buffer: C_DEPTH must be a power of two >= max(2, C_PIPE_LATENCY)");
   end

   logic [CW-1:0] credits_q, credits_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic          err_q, err_d;
   logic          pop, full, push_ok, drop, issue_err;

   always_comb begin
      pop       = (count_q != '0) && m_ready;
      full      = (count_q == DEPTH_C);
      // A full buffer still accepts a push when the head leaves in the same cycle.
      push_ok   = pipe_valid && (!full || pop);
      drop      = pipe_valid && full && !pop;
      issue_err = issue && (credits_q == '0) && !pop;

      credits_d = credits_q;
      count_d   = count_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      err_d     = err_q | drop | issue_err;

      if (issue && !pop) begin
         credits_d = (credits_q == '0) ? '0 : credits_q - CW'(1);
      end else if (pop && !issue) begin
         credits_d = credits_q + CW'(1);
      end

      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits_q <= DEPTH_C;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         credits_q <= credits_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         err_q     <= err_d;
      end
   end

   drain_buf_ram #(
      .DW    (C_DATA_WIDTH),
      .DEPTH (C_DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i     (clk),
      .wr_en_i   (push_ok),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (pipe_data),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (m_data)
   );

   assign m_valid  = (count_q != '0);
   assign count    = count_q;
   assign err      = err_q;
   assign issue_ok = (credits_q != '0) || pop;

endmodule

// File: tb/tb_pipe_drain_buffer.sv
// Directed bench for pipe_drain_buffer: queue-based reference model compared every cycle,
// plus literal expectations at the key scenario points.
module tb_pipe_drain_buffer;

   localparam int DW    = 16;
   localparam int LAT   = 4;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          issue = 1'b0;
   logic          issue_ok;
   logic          pipe_valid = 1'b0;
   logic [DW-1:0] pipe_data = '0;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready = 1'b0;
   logic [3:0]    count;
   logic          err;

   always #5 clk = ~clk;

   pipe_drain_buffer #(
      .C_DATA_WIDTH   (DW),
      .C_PIPE_LATENCY (LAT),
      .C_DEPTH        (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .issue      (issue),
      .issue_ok   (issue_ok),
      .pipe_valid (pipe_valid),
      .pipe_data  (pipe_data),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .count      (count),
      .err        (err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Reference model: the buffer is a bounded queue, credits a plain integer.
   logic [DW-1:0] mq[$];
   int            m_credits = DEPTH;
   bit            m_err = 1'b0;
   bit            mpop;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_credits = DEPTH;
         m_err     = 1'b0;
      end else begin
         mpop = (mq.size() != 0) && m_ready;
         if (mpop) void'(mq.pop_front());
         if (pipe_valid) begin
            if (mq.size() < DEPTH) mq.push_back(pipe_data);
            else m_err = 1'b1;
         end
         if (issue && !mpop) begin
            if (m_credits == 0) m_err = 1'b1;
            else m_credits--;
         end else if (mpop && !issue) begin
            m_credits++;
         end
      end
   end

   bit            cmp_en = 1'b0;
   bit            rec = 1'b0;
   logic [DW-1:0] got[$];

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_valid", m_valid, mq.size() != 0);
         if (mq.size() != 0) chk("m_data", m_data, mq[0]);
         chk("count", count, mq.size());
         chk("issue_ok", issue_ok, (m_credits != 0) || ((mq.size() != 0) && m_ready));
         chk("err", err, m_err);
         if (rec && m_valid && m_ready) got.push_back(m_data);
      end
   end

   // Upstream pipeline emulation: an issue shows up as pipe_valid LAT cycles later.
   logic [LAT-1:0] sr_v = '0;
   logic [DW-1:0]  sr_d [LAT];
   logic [DW-1:0]  next_d = 16'd1;

   task automatic apply(input logic iss, input logic mr, input logic fpv, input logic [DW-1:0] fpd);
      issue   = iss;
      m_ready = mr;
      if (fpv) begin
         pipe_valid = 1'b1;
         pipe_data  = fpd;
      end else begin
         pipe_valid = sr_v[LAT-1];
         pipe_data  = sr_d[LAT-1];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = LAT - 1; i > 0; i--) begin
         sr_v[i] = sr_v[i-1];
         sr_d[i] = sr_d[i-1];
      end
      sr_v[0] = issue;
      sr_d[0] = next_d;
      if (issue) next_d = next_d + 16'd1;
   endtask

   task automatic drive(input logic iss, input logic mr, input logic fpv, input logic [DW-1:0] fpd);
      apply(iss, mr, fpv, fpd);
      tick();
   endtask

   task automatic do_reset();
      rst    = 1'b0;
      sr_v   = '0;
      next_d = 16'd1;
      apply(1'b0, 1'b0, 1'b0, '0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < LAT; i++) sr_d[i] = '0;
      #1;
      rst = 1'b0;
      cmp_en = 1'b1;
      #1;
      chk("rst_count", count, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_issue_ok", issue_ok, 1);
      chk("rst_err", err, 0);
      do_reset();

      // Fill: 8 issues with no consumer, then let the results land.
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, '0);
      apply(1'b0, 1'b0, 1'b0, '0);
      #1;
      chk("fill_issue_ok_low", issue_ok, 0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, '0);
      apply(1'b0, 1'b0, 1'b0, '0);
      #1;
      chk("fill_count", count, 8);
      chk("fill_head", m_data, 16'h0001);
      chk("fill_err", err, 0);

      // Full buffer: pop and issue together, credits stay at zero.
      apply(1'b1, 1'b1, 1'b0, '0);
      #1;
      chk("pop_issue_ok", issue_ok, 1);
      tick();
      apply(1'b0, 1'b0, 1'b0, '0);
      #1;
      chk("pop_count", count, 7);
      chk("pop_credits_zero", issue_ok, 0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, '0);

      // Overflow push while full and not popping.
      drive(1'b0, 1'b0, 1'b1, 16'hDEAD);
      apply(1'b0, 1'b0, 1'b0, '0);
      #1;
      chk("ovf_err", err, 1);
      chk("ovf_count", count, 8);
      chk("ovf_head", m_data, 16'h0002);

      // Push and pop together while full: freed slot reused.
      drive(1'b0, 1'b1, 1'b1, 16'h0BEE);
      apply(1'b0, 1'b0, 1'b0, '0);
      #1;
      chk("fullpp_count", count, 8);
      chk("fullpp_head", m_data, 16'h0003);

      // Streaming: 12 words through with continuous pops, pointers wrap.
      do_reset();
      got.delete();
      rec = 1'b1;
      for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 1'b0, '0);
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, '0);
      rec = 1'b0;
      chk("stream_len", got.size(), 12);
      for (int i = 0; i < 12; i++) begin
         if (i < got.size()) chk("stream_word", got[i], i + 1);
      end
      chk("stream_err", err, 0);

      // Push and pop with a single stored word.
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 16'h00A1);
      apply(1'b0, 1'b1, 1'b1, 16'h00B2);
      #1;
      chk("one_head_before", m_data, 16'h00A1);
      chk("one_count_before", count, 1);
      tick();
      apply(1'b0, 1'b0, 1'b0, '0);
      #1;
      chk("one_valid_after", m_valid, 1);
      chk("one_head_after", m_data, 16'h00B2);
      chk("one_count_after", count, 1);

      // Issue with zero credits and no pop.
      do_reset();
      for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0, '0);
      apply(1'b0, 1'b0, 1'b0, '0);
      #1;
      chk("nocred_err", err, 1);
      chk("nocred_issue_ok", issue_ok, 0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, '0);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, '0);

      // Asynchronous reset mid-burst with five words stored.
      do_reset();
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 16'h0010 + 16'(i));
      apply(1'b0, 1'b0, 1'b0, '0);
      #1;
      chk("mid_count_before", count, 5);
      @(negedge clk);
      #2;
      rst    = 1'b0;
      sr_v   = '0;
      next_d = 16'd1;
      #1;
      chk("arst_count", count, 0);
      chk("arst_m_valid", m_valid, 0);
      chk("arst_issue_ok", issue_ok, 1);
      chk("arst_err", err, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, '0);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_drain_buffer.md
PIPE_DRAIN_BUFFER -- requirements
Module: pipe_drain_buffer

Interface
REQ-001 The block SHALL take parameter C_DATA_WIDTH, default 16, as the width of the pipeline result word.
REQ-002 The block SHALL take parameter C_PIPE_LATENCY, default 4, as the fixed issue-to-result latency of the upstream pipeline, legal range 1..64.
REQ-003 The block SHALL take parameter C_DEPTH, default 8, as the buffer depth in words: a power of two, at least C_PIPE_LATENCY and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-low.
REQ-006 The block SHALL have port issue, input, 1 bit, meaning upstream launched one item into the pipeline this cycle.
REQ-007 The block SHALL have port issue_ok, output, 1 bit, meaning upstream may assert issue this cycle.
REQ-008 The block SHALL have port pipe_valid, input, 1 bit, meaning a pipeline result arrives this cycle.
REQ-009 The block SHALL have port pipe_data, input, C_DATA_WIDTH bits, the arriving result.
REQ-010 The block SHALL have port m_valid, output, 1 bit, meaning the buffer head is available.
REQ-011 The block SHALL have port m_data, output, C_DATA_WIDTH bits, the buffer head word.
REQ-012 The block SHALL have port m_ready, input, 1 bit, meaning the consumer accepts the head.
REQ-013 The block SHALL have port count, output, clog2(C_DEPTH)+1 bits, the stored-word occupancy.
REQ-014 The block SHALL have port err, output, 1 bit, a sticky protocol-violation flag.

Function
REQ-015 Credits SHALL start at C_DEPTH, decrement on issue, increment on pop (m_valid and m_ready), and stay unchanged when both occur in the same cycle.
REQ-016 issue_ok SHALL be combinational: high when credits is nonzero, or when credits is zero and a pop occurs this cycle.
REQ-017 A push SHALL occur when pipe_valid is high: pipe_data is written at the write pointer, which advances modulo C_DEPTH.
REQ-018 Storage SHALL be first-word-fall-through: m_valid is high iff count is nonzero, and m_data equals the head word in the same cycle.
REQ-019 A pop SHALL advance the read pointer modulo C_DEPTH.
REQ-020 Simultaneous push and pop SHALL leave count unchanged, including when the buffer is full, where the freed slot is reused in the same cycle.
REQ-021 A push when full with no pop SHALL drop the data and set err; count and pointers stay unchanged.
REQ-022 issue while credits is zero and no pop occurs SHALL set err, and credits SHALL saturate at zero.
REQ-023 A pop when count is zero SHALL be impossible, since m_valid is low; m_ready alone has no effect.
REQ-024 err SHALL clear only on reset.
REQ-025 The block SHALL have zero latency from push to m_valid: a word pushed at edge N is visible after edge N.
REQ-026 Buffer storage SHALL hold no reset requirement; only control state is reset.

Reset
REQ-027 Reset assertion SHALL immediately force credits to C_DEPTH, count to 0, both pointers to 0, m_valid to 0, err to 0, and issue_ok to 1.
REQ-028 Reset mid-operation SHALL discard stored and in-flight words; upstream is responsible for flushing its pipeline under the same reset.
REQ-029 Reset deassertion SHALL be synchronised externally; the block uses it directly.

Structure
REQ-030 The shared package SHALL hold the clog2 constant function and the default width and depth constants.
REQ-031 Storage SHALL be one sub-module, drain_buf_ram: simple dual-port, C_DEPTH x C_DATA_WIDTH, with asynchronous read and synchronous write.
REQ-032 Credit and pointer logic SHALL reside in the top level, with no state machine beyond the counters.

Verification
REQ-033 Reset, then 8 issues with m_ready held 0 -> issue_ok falls after the 8th issue; 8 results arrive; count reaches 8; err stays 0.
REQ-034 Buffer full, m_ready=1 for one cycle with issue=1 that cycle -> credits stays 0, issue_ok is high that cycle, count steps 8->7.
REQ-035 Push with full buffer and no pop (forced pipe_valid) -> err=1, count stays 8, head data unchanged.
REQ-036 Push 0x0001..0x000C while popping continuously with latency 4 -> output order 0x0001..0x000C, pointers wrap past 7 cleanly.
REQ-037 Simultaneous push and pop with count=1 -> m_valid stays 1 and m_data changes to the new word on the next cycle.
REQ-038 Assert rst low mid-burst with count=5 -> count=0, m_valid=0, issue_ok=1 without waiting for a clock edge.
